ads124x_emu: RTL

- Synthesizable ADS124x device emulator: the SPI slave/target side of the ADS124x controller link, for hardware-in-the-loop and bench use without a physical ADC.
- Decodes the ADS124x command set from an SPI master (mode 1: CPOL=0, CPHA=1, MSB first) and holds a 16-byte register file.
- Generates DRDY from a conversion timer gated by START, and returns 24-bit samples taken from an AXI4-Stream source.

---
 rtl/ads124x_emu_pkg.sv | 42 ++++
 rtl/ads124x_emu_spi_if.sv | 100 ++++++++++
 rtl/ads124x_emu.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ads124x_emu_pkg.sv
// Shared constants and types for the ADS124x device emulator.
package ads124x_emu_pkg;

    // Smallest conversion period the timer supports.
    localparam int unsigned CONV_CYCLES_MIN = 4;

    // Command opcodes (single-byte commands ignore bit 0).
    localparam logic [7:0] OP_WAKEUP = 8'h00;
    localparam logic [7:0] OP_SLEEP  = 8'h02;
    localparam logic [7:0] OP_SYNC   = 8'h04;
    localparam logic [7:0] OP_RESET  = 8'h06;
    localparam logic [7:0] OP_RDATA  = 8'h12;
    localparam logic [7:0] OP_RDATAC = 8'h14;
    localparam logic [7:0] OP_SDATAC = 8'h16;
    localparam logic [7:0] OP_NOP    = 8'hFF;

    // Register access opcodes are matched on the upper nibble.
    localparam logic [3:0] OP_RREG = 4'h2;
    localparam logic [3:0] OP_WREG = 4'h4;

    // Power-on contents of the register file.
    localparam logic [7:0] REG_DEFAULTS [0:15] = '{
        8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    // Command/transfer sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ARG,
        ST_RREG_OUT,
        ST_WREG_IN,
        ST_DATA_OUT
    } emu_state_e;

    // True when a received byte is the given single-byte command.
    function automatic logic op_match(input logic [7:0] rx, input logic [7:0] op);
        return rx[7:1] == op[7:1];
    endfunction

endpackage

// File: rtl/ads124x_emu_spi_if.sv
// SPI mode-1 target pin interface: synchronizers, edge detection, rx byte
// assembly and a 24-bit tx shifter with parallel load.
module ads124x_emu_spi_if #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        din,
    input  logic        tx_load,
    input  logic [23:0] tx_data,
    input  logic        tx_clear,
    output logic        dout,
    output logic        cs_n_s,
    output logic        cs_fall_c,
    output logic        cs_rise_c,
    output logic        sclk_fall_c,
    output logic        rx_valid,
    output logic [7:0]  rx_byte
);

    localparam int unsigned MSB = SYNC_STAGES - 1;

    logic [MSB:0] sclk_q;
    logic [MSB:0] cs_q;
    logic [MSB:0] din_q;
    logic         sclk_d;
    logic         cs_d;
    logic         sclk_s;
    logic         din_s;
    logic         sclk_rise_c;
    logic [2:0]   bit_cnt;
    logic [6:0]   rx_sr;
    logic [23:0]  tx_sr;

    assign sclk_s      = sclk_q[MSB];
    assign din_s       = din_q[MSB];
    assign cs_n_s      = cs_q[MSB];
    assign sclk_rise_c = sclk_s & ~sclk_d & ~cs_n_s;
    assign sclk_fall_c = ~sclk_s & sclk_d & ~cs_n_s;
    assign cs_fall_c   = ~cs_n_s & cs_d;
    assign cs_rise_c   = cs_n_s & ~cs_d;

    // Bring the asynchronous pins into the aclk domain and keep last values for edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= '0;
            cs_q   <= '1;
            din_q  <= '0;
            sclk_d <= 1'b0;
            cs_d   <= 1'b1;
        end else begin
            sclk_q <= {sclk_q[MSB-1:0], sclk};
            cs_q   <= {cs_q[MSB-1:0], cs_n};
            din_q  <= {din_q[MSB-1:0], din};
            sclk_d <= sclk_s;
            cs_d   <= cs_n_s;
        end
    end

    // Assemble din bits on sclk falling edges; strobe on the 8th bit of each byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            rx_sr    <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (cs_n_s) begin
                bit_cnt <= '0;
            end else if (sclk_fall_c) begin
                rx_sr   <= {rx_sr[5:0], din_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_byte  <= {rx_sr, din_s};
                    rx_valid <= 1'b1;
                end
            end
        end
    end

    // Shift out MSB first on sclk rising edges; zeros follow once loaded data is gone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr <= '0;
            dout  <= 1'b0;
        end else if (tx_clear || cs_rise_c) begin
            tx_sr <= '0;
            dout  <= 1'b0;
        end else if (tx_load) begin
            tx_sr <= tx_data;
        end else if (sclk_rise_c) begin
            dout  <= tx_sr[23];
            tx_sr <= {tx_sr[22:0], 1'b0};
        end
    end

endmodule

// File: rtl/ads124x_emu.sv
// ADS124x device emulator top: command sequencer, register file and
// conversion timer feeding samples from an AXI4-Stream source.
module ads124x_emu
    import ads124x_emu_pkg::*;
#(
    parameter int unsigned CONV_CYCLES     = 1000,
    parameter int unsigned DIN_SYNC_STAGES = 2
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        din,
    output logic        dout,
    output logic        dout_t,
    input  logic        start,
    input  logic        reset_n,
    output logic        drdy,
    input  logic [23:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready
);

    localparam int unsigned CONV_EFF = (CONV_CYCLES < CONV_CYCLES_MIN) ? CONV_CYCLES_MIN : CONV_CYCLES;
    localparam int unsigned TIMER_W  = $clog2(CONV_EFF);
    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(CONV_EFF - 1);

    logic               cs_n_s;
    logic               cs_fall_c;
    logic               cs_rise_c;
    logic               sclk_fall_c;
    logic               rx_valid;
    logic [7:0]         rx_byte;
    logic               tx_load;
    logic [23:0]        tx_data;
    logic               tx_clear;

    logic [1:0]         reset_n_q;
    logic               reset_n_s;
    emu_state_e         state;
    logic               is_wreg;
    logic [3:0]         addr;
    logic [3:0]         cnt;
    logic [1:0]         data_cnt;
    logic               auto_rd;
    logic [1:0]         auto_cnt;
    logic               rd_first;
    logic               rdatac;
    logic [7:0]         regs [0:15];
    logic [23:0]        data_reg;
    logic [TIMER_W-1:0] timer;

    logic               cmd_byte_c;
    logic               cmd_reset_c;
    logic               soft_rst_c;
    logic               sync_c;
    logic               readout_fall_c;

    assign dout_t         = cs_n_s;
    assign reset_n_s      = reset_n_q[1];
    assign cmd_byte_c     = rx_valid && (state == ST_CMD);
    assign cmd_reset_c    = cmd_byte_c && op_match(rx_byte, OP_RESET);
    assign soft_rst_c     = !reset_n_s || cmd_reset_c;
    assign sync_c         = cmd_byte_c && !auto_rd && op_match(rx_byte, OP_SYNC);
    assign readout_fall_c = sclk_fall_c && rd_first;

    ads124x_emu_spi_if #(
        .SYNC_STAGES (DIN_SYNC_STAGES)
    ) u_spi_if (
        .clk         (aclk),
        .rst_n       (aresetn),
        .sclk        (sclk),
        .cs_n        (cs_n),
        .din         (din),
        .tx_load     (tx_load),
        .tx_data     (tx_data),
        .tx_clear    (tx_clear),
        .dout        (dout),
        .cs_n_s      (cs_n_s),
        .cs_fall_c   (cs_fall_c),
        .cs_rise_c   (cs_rise_c),
        .sclk_fall_c (sclk_fall_c),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte)
    );

    // Two-flop synchronizer for the device RESET pin.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            reset_n_q <= 2'b11;
        end else begin
            reset_n_q <= {reset_n_q[0], reset_n};
        end
    end

    // Command sequencer and register file.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= ST_IDLE;
            is_wreg  <= 1'b0;
            addr     <= '0;
            cnt      <= '0;
            data_cnt <= '0;
            auto_rd  <= 1'b0;
            auto_cnt <= '0;
            rd_first <= 1'b0;
            rdatac   <= 1'b1;
            tx_load  <= 1'b0;
            tx_data  <= '0;
            tx_clear <= 1'b0;
            for (int i = 0; i < 16; i++) regs[i] <= REG_DEFAULTS[i];
        end else if (soft_rst_c) begin
            // Device reset ignores the rest of a pin-reset transaction; a RESET command keeps decoding.
            state    <= reset_n_s ? ST_CMD : ST_IDLE;
            auto_rd  <= 1'b0;
            rd_first <= 1'b0;
            rdatac   <= 1'b1;
            tx_load  <= 1'b0;
            tx_clear <= 1'b1;
            for (int i = 0; i < 16; i++) regs[i] <= REG_DEFAULTS[i];
        end else begin
            tx_load  <= 1'b0;
            tx_clear <= 1'b0;
            if (cs_rise_c) begin
                state    <= ST_IDLE;
                auto_rd  <= 1'b0;
                rd_first <= 1'b0;
            end else begin
                if (readout_fall_c) rd_first <= 1'b0;
                case (state)
                    ST_IDLE: begin
                        if (cs_fall_c) begin
                            state <= ST_CMD;
                            if (rdatac && !drdy) begin
                                tx_load  <= 1'b1;
                                tx_data  <= data_reg;
                                auto_rd  <= 1'b1;
                                auto_cnt <= 2'd2;
                                rd_first <= 1'b1;
                            end
                        end
                    end
                    ST_CMD: begin
                        if (rx_valid) begin
                            if (auto_rd) begin
                                if (auto_cnt == 2'd0) auto_rd <= 1'b0;
                                else auto_cnt <= auto_cnt - 2'd1;
                                if (op_match(rx_byte, OP_SDATAC)) rdatac <= 1'b0;
                            end else if (op_match(rx_byte, OP_RDATA)) begin
                                state    <= ST_DATA_OUT;
                                tx_load  <= 1'b1;
                                tx_data  <= data_reg;
                                data_cnt <= 2'd2;
                                rd_first <= 1'b1;
                            end else if (op_match(rx_byte, OP_RDATAC)) begin
                                rdatac <= 1'b1;
                            end else if (op_match(rx_byte, OP_SDATAC)) begin
                                rdatac <= 1'b0;
                            end else if (rx_byte[7:4] == OP_RREG || rx_byte[7:4] == OP_WREG) begin
                                state   <= ST_ARG;
                                is_wreg <= (rx_byte[7:4] == OP_WREG);
                                addr    <= rx_byte[3:0];
                            end else if (op_match(rx_byte, OP_WAKEUP) || op_match(rx_byte, OP_SLEEP) ||
                                         rx_byte == OP_NOP) begin
                                state <= ST_CMD;
                            end
                        end
                    end
                    ST_ARG: begin
                        if (rx_valid) begin
                            cnt <= rx_byte[3:0];
                            if (is_wreg) begin
                                state <= ST_WREG_IN;
                            end else begin
                                state   <= ST_RREG_OUT;
                                tx_load <= 1'b1;
                                tx_data <= {regs[addr], 16'h0000};
                            end
                        end
                    end
                    ST_RREG_OUT: begin
                        if (rx_valid) begin
                            if (cnt == 4'd0) begin
                                state <= ST_CMD;
                            end else begin
                                cnt     <= cnt - 4'd1;
                                addr    <= addr + 4'd1;
                                tx_load <= 1'b1;
                                tx_data <= {regs[4'(addr + 4'd1)], 16'h0000};
                            end
                        end
                    end
                    ST_WREG_IN: begin
                        if (rx_valid) begin
                            regs[addr] <= rx_byte;
                            addr       <= addr + 4'd1;
                            if (cnt == 4'd0) state <= ST_CMD;
                            else cnt <= cnt - 4'd1;
                        end
                    end
                    ST_DATA_OUT: begin
                        if (rx_valid) begin
                            if (data_cnt == 2'd0) state <= ST_CMD;
                            else data_cnt <= data_cnt - 2'd1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Conversion timer, sample capture and DRDY generation.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            timer         <= TIMER_RELOAD;
            drdy          <= 1'b1;
            data_reg      <= '0;
            s_axis_tready <= 1'b0;
        end else if (soft_rst_c) begin
            timer         <= TIMER_RELOAD;
            drdy          <= 1'b1;
            data_reg      <= '0;
            s_axis_tready <= 1'b0;
        end else begin
            s_axis_tready <= 1'b0;
            if (readout_fall_c) drdy <= 1'b1;
            if (sync_c || !start) begin
                timer <= TIMER_RELOAD;
            end else if (timer == '0) begin
                if (s_axis_tvalid) begin
                    data_reg      <= s_axis_tdata;
                    s_axis_tready <= 1'b1;
                end
                drdy  <= 1'b0;
                timer <= TIMER_RELOAD;
            end else begin
                if (timer == TIMER_W'(1)) drdy <= 1'b1;
                timer <= timer - TIMER_W'(1);
            end
        end
    end

endmodule
